// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and constants for the Booth multiplier controller.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    localparam int c_booth_n = 4;

    // {x0, e} pairs that require an adder operation in CHECK
    localparam logic [1:0] c_pair_add = 2'b01;
    localparam logic [1:0] c_pair_sub = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_Y = 3'd1,
        LOAD_X = 3'd2,
        CHECK  = 3'd3,
        SHIFT  = 3'd4,
        OUT_HI = 3'd5,
        OUT_LO = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_counter.sv
`default_nettype none
// ============================================================================
// Module      : booth_counter
// Description : Booth iteration counter with clear, increment and terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_counter #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int c_cnt_w = (N > 1) ? $clog2(N) : 1;

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Reflects the count before the pending increment is applied
    assign tc = (r_count == c_cnt_w'(N - 1));

endmodule
`default_nettype wire

// File: rtl/booth_controller.sv
`default_nettype none
// ============================================================================
// Module      : booth_controller
// Description : Control FSM sequencing a radix-2 Booth multiplier datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_controller
    import booth_pkg::*;
#(
    parameter int N = c_booth_n
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic x0,
    input  logic e,
    output logic ldY,
    output logic clrE,
    output logic ldE,
    output logic clrA,
    output logic ldA,
    output logic shA,
    output logic ldX,
    output logic shX,
    output logic sub,
    output logic sel,
    output logic ready,
    output logic out_valid
);

    state_t r_state;
    state_t w_next_state;
    logic   w_cnt_clr;
    logic   w_cnt_inc;
    logic   w_cnt_tc;

    booth_counter #(
        .N (N)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .clr (w_cnt_clr),
        .inc (w_cnt_inc),
        .tc  (w_cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        ldY          = 1'b0;
        clrE         = 1'b0;
        ldE          = 1'b0;
        clrA         = 1'b0;
        ldA          = 1'b0;
        shA          = 1'b0;
        ldX          = 1'b0;
        shX          = 1'b0;
        sub          = 1'b0;
        sel          = 1'b0;
        ready        = 1'b0;
        out_valid    = 1'b0;

        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next_state = LOAD_Y;
                end
            end
            LOAD_Y: begin
                ldY          = 1'b1;
                clrA         = 1'b1;
                clrE         = 1'b1;
                w_next_state = LOAD_X;
            end
            LOAD_X: begin
                ldX          = 1'b1;
                w_cnt_clr    = 1'b1;
                w_next_state = CHECK;
            end
            CHECK: begin
                // Mealy decode: equal bits mean a pure shift this iteration
                if ({x0, e} == c_pair_sub) begin
                    ldA = 1'b1;
                    sub = 1'b1;
                end else if ({x0, e} == c_pair_add) begin
                    ldA = 1'b1;
                end
                w_next_state = SHIFT;
            end
            SHIFT: begin
                shA          = 1'b1;
                shX          = 1'b1;
                ldE          = 1'b1;
                w_cnt_inc    = 1'b1;
                w_next_state = w_cnt_tc ? OUT_HI : CHECK;
            end
            OUT_HI: begin
                out_valid    = 1'b1;
                w_next_state = OUT_LO;
            end
            OUT_LO: begin
                sel          = 1'b1;
                out_valid    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_controller
// Description : Self-checking bench for booth_controller with a behavioural datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_controller;
    import booth_pkg::*;

    localparam int N = 4;

    // Output vector bit order:
    // {ready, ldY, clrE, ldE, clrA, ldA, shA, ldX, shX, sub, sel, out_valid}
    localparam logic [11:0] OV_IDLE  = 12'b1000_0000_0000;
    localparam logic [11:0] OV_LDY   = 12'b0110_1000_0000;
    localparam logic [11:0] OV_LDX   = 12'b0000_0001_0000;
    localparam logic [11:0] OV_SUB   = 12'b0000_0100_0100;
    localparam logic [11:0] OV_ADD   = 12'b0000_0100_0000;
    localparam logic [11:0] OV_NOP   = 12'b0000_0000_0000;
    localparam logic [11:0] OV_SHIFT = 12'b0001_0010_1000;
    localparam logic [11:0] OV_HI    = 12'b0000_0000_0001;
    localparam logic [11:0] OV_LO    = 12'b0000_0000_0011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic x0_drv = 1'b0;
    logic e_drv = 1'b0;
    logic dp_mode = 1'b0;
    logic x0, e;
    logic ldY, clrE, ldE, clrA, ldA, shA, ldX, shX, sub, sel, ready, out_valid;
    logic [11:0] outs;

    logic [3:0] din = 4'd0;
    logic [3:0] dp_a = 4'd0;
    logic [3:0] dp_x = 4'd0;
    logic [3:0] dp_y = 4'd0;
    logic       dp_e = 1'b0;
    logic [3:0] data_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        start;
        logic        x0;
        logic        e;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    booth_controller #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x0        (x0),
        .e         (e),
        .ldY       (ldY),
        .clrE      (clrE),
        .ldE       (ldE),
        .clrA      (clrA),
        .ldA       (ldA),
        .shA       (shA),
        .ldX       (ldX),
        .shX       (shX),
        .sub       (sub),
        .sel       (sel),
        .ready     (ready),
        .out_valid (out_valid)
    );

    assign outs = {ready, ldY, clrE, ldE, clrA, ldA, shA, ldX, shX, sub, sel, out_valid};

    // Behavioural 4-bit Booth datapath driven by the controller strobes
    always @(posedge clk) begin
        if (ldY)  dp_y <= din;
        if (clrA) dp_a <= 4'd0;
        if (clrE) dp_e <= 1'b0;
        if (ldX)  dp_x <= din;
        if (ldA)  dp_a <= sub ? (dp_a - dp_y) : (dp_a + dp_y);
        if (shA)  dp_a <= {dp_a[3], dp_a[3:1]};
        if (shX)  dp_x <= {dp_a[0], dp_x[3:1]};
        if (ldE)  dp_e <= dp_x[0];
    end

    assign x0       = dp_mode ? dp_x[0] : x0_drv;
    assign e        = dp_mode ? dp_e    : e_drv;
    assign data_out = sel ? dp_x : dp_a;

    // Datapath strobes that must never coincide
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if ($countones({ldA, shA, ldX, ldY}) > 1) begin
                bad++;
                $display("FAIL onehot @%0t: got ldA/shA/ldX/ldY=%b required at most one set",
                         $time, {ldA, shA, ldX, ldY});
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [11:0] act,
                       input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] @%0t: got %b required %b", name, idx, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic s, input logic xx, input logic ee,
                           input logic [11:0] ex);
        tbl[i].start = s;
        tbl[i].x0    = xx;
        tbl[i].e     = ee;
        tbl[i].exp   = ex;
    endtask

    // One full operation from IDLE; inject=1 also pulses start in two CHECK cycles
    task automatic run_table(input string name, input bit inject);
        for (int i = 0; i < 14; i++) begin
            start  = tbl[i].start | (inject && (i == 3 || i == 7));
            x0_drv = tbl[i].x0;
            e_drv  = tbl[i].e;
            #2;
            chk(name, i, outs, tbl[i].exp);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic wait_ready(input int limit);
        int k;
        k = 0;
        while (!ready && k < limit) begin
            tick();
            k++;
        end
        chk("ready_timeout", k, {11'd0, ready}, 12'd1);
    endtask

    initial begin
        set_vec(0,  1'b1, 1'b0, 1'b0, OV_IDLE);
        set_vec(1,  1'b0, 1'b1, 1'b0, OV_LDY);
        set_vec(2,  1'b0, 1'b1, 1'b0, OV_LDX);
        set_vec(3,  1'b0, 1'b1, 1'b0, OV_SUB);
        set_vec(4,  1'b0, 1'b1, 1'b0, OV_SHIFT);
        set_vec(5,  1'b0, 1'b0, 1'b1, OV_ADD);
        set_vec(6,  1'b0, 1'b1, 1'b1, OV_SHIFT);
        set_vec(7,  1'b0, 1'b0, 1'b0, OV_NOP);
        set_vec(8,  1'b0, 1'b0, 1'b1, OV_SHIFT);
        set_vec(9,  1'b0, 1'b1, 1'b1, OV_NOP);
        set_vec(10, 1'b0, 1'b1, 1'b0, OV_SHIFT);
        set_vec(11, 1'b0, 1'b1, 1'b0, OV_HI);
        set_vec(12, 1'b0, 1'b0, 1'b1, OV_LO);
        set_vec(13, 1'b0, 1'b0, 1'b0, OV_IDLE);

        // Reset held: idle outputs
        #3;
        chk("in_reset", 0, outs, OV_IDLE);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            chk("idle_outs", i, outs, OV_IDLE);
            chk("idle_state", i, 12'(dut.r_state), 12'(IDLE));
            tick();
        end

        run_table("trace", 1'b0);
        run_table("trace_start_in_check", 1'b1);

        // Paired with datapath: Y=-6, X=-3 -> +18
        dp_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        din = 4'b1010;
        tick();
        din = 4'b1101;
        tick();
        begin
            int k;
            k = 0;
            while (!out_valid && k < 20) begin
                tick();
                k++;
            end
            chk("dp_latency", 0, 12'(k), 12'd8);
        end
        chk("dp_hi", 0, {7'd0, sel, data_out}, {7'd0, 1'b0, 4'b0001});
        tick();
        chk("dp_lo", 0, {6'd0, out_valid, sel, data_out}, {6'd0, 1'b1, 1'b1, 4'b0010});
        tick();
        dp_mode = 1'b0;
        wait_ready(5);

        // start held high: ready for exactly one cycle between operations
        start = 1'b1;
        for (int i = 0; i < 27; i++) begin
            #2;
            chk("b2b_ready_ldy", i, {10'd0, ready, ldY},
                {10'd0, (i % 13 == 0) ? 1'b1 : 1'b0, (i % 13 == 1) ? 1'b1 : 1'b0});
            tick();
        end
        start = 1'b0;
        wait_ready(20);

        // Asynchronous reset in the second SHIFT
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_rst_shift", 0, outs, OV_SHIFT);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outs", 0, outs, OV_IDLE);
        chk("async_rst_cnt", 0, 12'(dut.u_counter.r_count), 12'd0);
        #1;
        rst = 1'b0;
        run_table("after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_controller.md
BOOTH_CONTROLLER -- requirements
Module: booth_controller

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the operand width in bits and therefore the Booth iteration count.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-005 The module SHALL have port x0, input, 1 bit: LSB of the datapath X register.
REQ-006 The module SHALL have port e, input, 1 bit: the datapath E (Q-1) flip-flop value.
REQ-007 The module SHALL have ports ldY, clrE, ldE, clrA, ldA, shA, ldX and shX, each output, 1 bit: the datapath load, clear and shift strobes, all active-high.
REQ-008 The module SHALL have port sub, output, 1 bit: adder mode; 1 means A <= A - Y, 0 means A <= A + Y, and it is meaningful only when ldA=1.
REQ-009 The module SHALL have port sel, output, 1 bit: datapath output select; 0 selects A (high nibble), 1 selects X (low nibble).
REQ-010 The module SHALL have port ready, output, 1 bit: idle and accepting start.
REQ-011 The module SHALL have port out_valid, output, 1 bit: data_out from the datapath holds a product nibble this cycle.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, LOAD_Y, LOAD_X, CHECK, SHIFT, OUT_HI, OUT_LO.
REQ-013 In IDLE, ready=1 and all strobes=0; start=1 SHALL move to LOAD_Y, and start=0 SHALL stay in IDLE.
REQ-014 In LOAD_Y, ldY=1, clrA=1 and clrE=1 for one cycle, and the operand on data_in is captured into Y; the FSM then goes unconditionally to LOAD_X.
REQ-015 In LOAD_X, ldX=1 for one cycle and the iteration counter is cleared to 0; the FSM then goes to CHECK.
REQ-016 In CHECK, outputs SHALL be Mealy on {x0,e}: 2'b10 gives ldA=1, sub=1; 2'b01 gives ldA=1, sub=0; 2'b00 or 2'b11 gives ldA=0. The FSM then goes to SHIFT.
REQ-017 In SHIFT, shA=1, shX=1 and ldE=1 (E takes the pre-shift x0), and the counter increments.
REQ-018 From SHIFT, the FSM SHALL go to OUT_HI when the pre-increment counter equals N-1, and to CHECK otherwise, giving exactly N CHECK/SHIFT pairs.
REQ-019 The counter SHALL be clog2(N) bits wide; its wrap from N-1 to 0 is harmless because LOAD_X reloads it.
REQ-020 In OUT_HI, sel=0 and out_valid=1; the FSM then goes to OUT_LO.
REQ-021 In OUT_LO, sel=1 and out_valid=1; the FSM then goes to IDLE.
REQ-022 Latency SHALL be fixed: with start sampled high at edge 0, out_valid is high in cycles 2N+3 and 2N+4 (11 and 12 for N=4), and ready returns in cycle 2N+5.
REQ-023 start SHALL be ignored in every state except IDLE; a start held high through OUT_LO SHALL begin a new operation immediately after return to IDLE.
REQ-024 At most one of ldA, shA, ldX and ldY SHALL be high in any cycle.
REQ-025 sel SHALL be 0 in every state except OUT_LO.
REQ-026 Outputs not listed for a state SHALL be 0 in that state.

Reset
REQ-027 Asserting rst at any time, including mid-operation, SHALL force IDLE and counter=0 immediately, without waiting for a clock edge.
REQ-028 While rst is high, all strobes, sub, sel and out_valid SHALL be 0 and ready SHALL be 1.
REQ-029 On the first edge after rst deasserts, the FSM SHALL sample start normally.

Structure
REQ-030 A shared package booth_pkg SHALL hold the state enumeration type, the default width constant N=4, and the {x0,e} pair encodings used for decoding (ADD=2'b01, SUB=2'b10).
REQ-031 The iteration counter SHALL be one sub-module, booth_counter, with clear, increment and terminal-count outputs; the FSM and the output decode SHALL live in booth_controller.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Reset then idle, start=0 for 5 cycles -> ready=1, all strobes 0, state IDLE.
- Start pulse, x0/e driven 10,01,00,11 across the four CHECK cycles -> ldA/sub = 1/1, 1/0, 0/-, 0/-; exactly 4 shA/shX/ldE pulses; out_valid in cycles 11 and 12 with sel 0 then 1.
- Controller paired with the datapath, Y=4'b1010, X=4'b1101 -> data_out 4'b0001 then 4'b0010 (product 8'h12 = +18).
- start held high continuously -> back-to-back operations, ready high exactly 1 cycle between them, no missed or duplicated LOAD_Y.
- rst asserted asynchronously mid-SHIFT of iteration 2 -> outputs 0 and ready=1 before the next edge; a fresh start then gives the full 12-cycle sequence.
- start pulsed during CHECK -> ignored; operation length unchanged.
